// File: rtl/dm_access_ctrl.sv
// Data-memory access stage: turns ID/EX load/store requests into a req/ack
// memory transaction, stalls the pipeline while busy and aborts hung accesses.
module dm_access_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_re_ID_EX,
  input  logic              dm_we_ID_EX,
  input  logic [ADDR_W-1:0] addr_ID_EX,
  input  logic [15:0]       wrt_data_ID_EX,
  input  logic              stall_in,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       dm_rd_data_EX_DM,
  output logic              dm_re_EX_DM,
  output logic              stall_DM,
  output logic              dm_err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Last counter value at which a missing ack becomes a timeout.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic [7:0]        tmo_cnt, tmo_cnt_nxt;
  logic              accept, done, timeout;
  logic              req_nxt, we_nxt, rd_re_nxt, err_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [15:0]       wdata_nxt, rd_nxt;

  // Handshake: mem_req rises after the accepting edge and stays high, with
  // mem_we/mem_addr/mem_wdata frozen, until the edge that samples mem_ack=1
  // (or the timeout edge); mem_ack is a single-cycle pulse, ignored in IDLE.
  assign accept  = (state == IDLE) & (dm_re_ID_EX | dm_we_ID_EX) & ~stall_in;
  assign done    = (state == BUSY) & mem_ack;
  assign timeout = (state == BUSY) & ~mem_ack & (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_DM    = (state == BUSY) & ~mem_ack;
    req_nxt     = mem_req;
    we_nxt      = mem_we;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    rd_nxt      = dm_rd_data_EX_DM;
    rd_re_nxt   = 1'b0;
    tmo_cnt_nxt = tmo_cnt;
    err_nxt     = err_clr ? 1'b0 : dm_err;
    if (accept) begin
      // A store wins over a simultaneous load.
      req_nxt     = 1'b1;
      we_nxt      = dm_we_ID_EX;
      addr_nxt    = addr_ID_EX;
      wdata_nxt   = wrt_data_ID_EX;
      tmo_cnt_nxt = 8'd0;
    end else if (done) begin
      req_nxt     = 1'b0;
      tmo_cnt_nxt = 8'd0;
      if (!mem_we) begin
        rd_nxt    = mem_rdata;
        rd_re_nxt = 1'b1;
      end
    end else if (timeout) begin
      // Aborted loads still hand writeback a deterministic zero.
      req_nxt     = 1'b0;
      tmo_cnt_nxt = 8'd0;
      err_nxt     = 1'b1;
      if (!mem_we) begin
        rd_nxt    = 16'h0000;
        rd_re_nxt = 1'b1;
      end
    end else if (state == BUSY) begin
      tmo_cnt_nxt = tmo_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= 16'h0000;
      dm_rd_data_EX_DM <= 16'h0000;
      dm_re_EX_DM      <= 1'b0;
      dm_err           <= 1'b0;
      tmo_cnt          <= 8'd0;
    end else begin
      mem_req          <= req_nxt;
      mem_we           <= we_nxt;
      mem_addr         <= addr_nxt;
      mem_wdata        <= wdata_nxt;
      dm_rd_data_EX_DM <= rd_nxt;
      dm_re_EX_DM      <= rd_re_nxt;
      dm_err           <= err_nxt;
      tmo_cnt          <= tmo_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Cycle-level vector bench for dm_access_ctrl (TIMEOUT_CYC=8), with a
// load-result scoreboard and a hand-written mid-access reset sequence.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dm_re_ID_EX, dm_we_ID_EX, stall_in, err_clr, mem_ack;
  logic [15:0] addr_ID_EX, wrt_data_ID_EX, mem_rdata;
  logic        mem_req, mem_we, dm_re_EX_DM, stall_DM, dm_err;
  logic [15:0] mem_addr, mem_wdata, dm_rd_data_EX_DM;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        re, we;
    logic [15:0] addr, wdata;
    logic        stall_in, err_clr, ack;
    logic [15:0] rdata;
    logic        x_stall, x_req, x_we;
    logic [15:0] x_addr, x_wdata, x_rd;
    logic        x_rd_re, x_err;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          split;

  dm_access_ctrl #(.TIMEOUT_CYC(8), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .dm_re_ID_EX(dm_re_ID_EX), .dm_we_ID_EX(dm_we_ID_EX),
    .addr_ID_EX(addr_ID_EX), .wrt_data_ID_EX(wrt_data_ID_EX),
    .stall_in(stall_in), .err_clr(err_clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dm_rd_data_EX_DM(dm_rd_data_EX_DM), .dm_re_EX_DM(dm_re_EX_DM),
    .stall_DM(stall_DM), .dm_err(dm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int step, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", nm, step, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic re, input logic we,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic sti, input logic clr, input logic ack,
                              input logic [15:0] rdata, input logic x_stall,
                              input logic x_req, input logic x_we,
                              input logic [15:0] x_addr, input logic [15:0] x_wdata,
                              input logic [15:0] x_rd, input logic x_rd_re, input logic x_err);
    vec_t v;
    v.nm = nm; v.re = re; v.we = we; v.addr = addr; v.wdata = wdata;
    v.stall_in = sti; v.err_clr = clr; v.ack = ack; v.rdata = rdata;
    v.x_stall = x_stall; v.x_req = x_req; v.x_we = x_we; v.x_addr = x_addr;
    v.x_wdata = x_wdata; v.x_rd = x_rd; v.x_rd_re = x_rd_re; v.x_err = x_err;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs.push_back(v);
    if (v.x_rd_re) exp_q.push_back(v.x_rd);
  endtask

  task automatic check_regs(input string nm, input int step, input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] rd, input logic rd_re, input logic err);
    check({nm, ".mem_req"}, step, 16'(mem_req), 16'(req));
    check({nm, ".mem_we"}, step, 16'(mem_we), 16'(we));
    check({nm, ".mem_addr"}, step, mem_addr, addr);
    check({nm, ".mem_wdata"}, step, mem_wdata, wdata);
    check({nm, ".rd_data"}, step, dm_rd_data_EX_DM, rd);
    check({nm, ".dm_re"}, step, 16'(dm_re_EX_DM), 16'(rd_re));
    check({nm, ".dm_err"}, step, 16'(dm_err), 16'(err));
  endtask

  task automatic apply_vec(input vec_t v, input int step);
    @(negedge clk);
    dm_re_ID_EX = v.re; dm_we_ID_EX = v.we; addr_ID_EX = v.addr; wrt_data_ID_EX = v.wdata;
    stall_in = v.stall_in; err_clr = v.err_clr; mem_ack = v.ack; mem_rdata = v.rdata;
    #1 check({v.nm, ".stall_DM"}, step, 16'(stall_DM), 16'(v.x_stall));
    @(posedge clk);
    #1 check_regs(v.nm, step, v.x_req, v.x_we, v.x_addr, v.x_wdata, v.x_rd, v.x_rd_re, v.x_err);
  endtask

  // Scoreboard for load results handed to writeback.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dm_re_EX_DM === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got load result %h, expected none", dm_rd_data_EX_DM);
      end else begin
        check("sb_load", checks, dm_rd_data_EX_DM, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Load 0x0040, ack three cycles later; request inputs ignored while busy.
    add(mk("ld_go",    1,0,16'h0040,16'h0000,0,0,0,16'h0000, 0, 1,0,16'h0040,16'h0000,16'h0000,0,0));
    add(mk("ld_ign",   1,1,16'hFFFF,16'hAAAA,0,0,0,16'h0000, 1, 1,0,16'h0040,16'h0000,16'h0000,0,0));
    add(mk("ld_wait",  0,0,16'h0000,16'h0000,0,0,0,16'h0000, 1, 1,0,16'h0040,16'h0000,16'h0000,0,0));
    add(mk("ld_wait",  0,0,16'h0000,16'h0000,0,0,0,16'h0000, 1, 1,0,16'h0040,16'h0000,16'h0000,0,0));
    add(mk("ld_ack",   0,0,16'h0000,16'h0000,0,0,1,16'hBEEF, 0, 0,0,16'h0040,16'h0000,16'hBEEF,1,0));
    add(mk("idle_ack", 0,0,16'h0000,16'h0000,0,0,1,16'h1111, 0, 0,0,16'h0040,16'h0000,16'hBEEF,0,0));
    // Store with 1-cycle ack, then back-to-back simultaneous re/we.
    add(mk("st_go",    0,1,16'h0010,16'h1234,0,0,0,16'h0000, 0, 1,1,16'h0010,16'h1234,16'hBEEF,0,0));
    add(mk("st_ack",   0,0,16'h0000,16'h0000,0,0,1,16'h5555, 0, 0,1,16'h0010,16'h1234,16'hBEEF,0,0));
    add(mk("rw_go",    1,1,16'h0020,16'hABCD,0,0,0,16'h0000, 0, 1,1,16'h0020,16'hABCD,16'hBEEF,0,0));
    add(mk("rw_ack",   0,0,16'h0000,16'h0000,0,0,1,16'h7777, 0, 0,1,16'h0020,16'hABCD,16'hBEEF,0,0));
    // Downstream stall holds off acceptance.
    add(mk("stl_hold", 1,0,16'h0030,16'h0000,1,0,0,16'h0000, 0, 0,1,16'h0020,16'hABCD,16'hBEEF,0,0));
    add(mk("stl_hold", 1,0,16'h0030,16'h0000,1,0,0,16'h0000, 0, 0,1,16'h0020,16'hABCD,16'hBEEF,0,0));
    add(mk("stl_go",   1,0,16'h0030,16'h0000,0,0,0,16'h0000, 0, 1,0,16'h0030,16'h0000,16'hBEEF,0,0));
    add(mk("stl_ack",  0,0,16'h0000,16'h0000,0,0,1,16'h0C0C, 0, 0,0,16'h0030,16'h0000,16'h0C0C,1,0));
    // Load timeout with err_clr on the same edge: set wins; then clear.
    add(mk("tmo_go",   1,0,16'h0050,16'h0000,0,0,0,16'h0000, 0, 1,0,16'h0050,16'h0000,16'h0C0C,0,0));
    for (int i = 0; i < 7; i++)
      add(mk("tmo_wait", 0,0,16'h0000,16'h0000,0,0,0,16'h0000, 1, 1,0,16'h0050,16'h0000,16'h0C0C,0,0));
    add(mk("tmo_hit",  0,0,16'h0000,16'h0000,0,1,0,16'h0000, 1, 0,0,16'h0050,16'h0000,16'h0000,1,1));
    add(mk("err_clr",  0,0,16'h0000,16'h0000,0,1,0,16'h0000, 0, 0,0,16'h0050,16'h0000,16'h0000,0,0));
    // Store acked exactly on the timeout cycle is a success.
    add(mk("sta_go",   0,1,16'h0060,16'h9999,0,0,0,16'h0000, 0, 1,1,16'h0060,16'h9999,16'h0000,0,0));
    for (int i = 0; i < 7; i++)
      add(mk("sta_wait", 0,0,16'h0000,16'h0000,0,0,0,16'h0000, 1, 1,1,16'h0060,16'h9999,16'h0000,0,0));
    add(mk("sta_ack",  0,0,16'h0000,16'h0000,0,0,1,16'h1357, 0, 0,1,16'h0060,16'h9999,16'h0000,0,0));
    // Start a load that reset will interrupt.
    add(mk("rst_go",   1,0,16'h0070,16'h0000,0,0,0,16'h0000, 0, 1,0,16'h0070,16'h0000,16'h0000,0,0));
    add(mk("rst_wait", 0,0,16'h0000,16'h0000,0,0,0,16'h0000, 1, 1,0,16'h0070,16'h0000,16'h0000,0,0));
    split = vecs.size();
    add(mk("late_ack", 0,0,16'h0000,16'h0000,0,0,1,16'hDEAD, 0, 0,0,16'h0000,16'h0000,16'h0000,0,0));
    add(mk("post_go",  1,0,16'h0080,16'h0000,0,0,0,16'h0000, 0, 1,0,16'h0080,16'h0000,16'h0000,0,0));
    add(mk("post_ack", 0,0,16'h0000,16'h0000,0,0,1,16'h4242, 0, 0,0,16'h0080,16'h0000,16'h4242,1,0));
    add(mk("post_idl", 0,0,16'h0000,16'h0000,0,0,0,16'h0000, 0, 0,0,16'h0080,16'h0000,16'h4242,0,0));

    // Reset state.
    rst_n = 1'b0;
    dm_re_ID_EX = 0; dm_we_ID_EX = 0; addr_ID_EX = 0; wrt_data_ID_EX = 0;
    stall_in = 0; err_clr = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1 check_regs("reset", 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    check("reset.stall_DM", 0, 16'(stall_DM), 16'h0000);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < split; i++) apply_vec(vecs[i], i);

    // Asynchronous reset mid-access: outputs drop without a clock edge.
    @(negedge clk);
    dm_re_ID_EX = 0; dm_we_ID_EX = 0; mem_ack = 0;
    #1 check("pre_rst.stall_DM", split, 16'(stall_DM), 16'h0001);
    #1 rst_n = 1'b0;
    #1 check_regs("async_rst", split, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    check("async_rst.stall_DM", split, 16'(stall_DM), 16'h0000);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int i = split; i < vecs.size(); i++) apply_vec(vecs[i], i);

    @(negedge clk);
    check("sb_drained", vecs.size(), 16'(exp_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Data-memory access stage of the 16-bit pipeline, between EX and the DM/WB writeback mux.
- Takes load/store requests from the ID/EX boundary and drives a variable-latency memory port using a req/ack handshake.
- Produces dm_rd_data_EX_DM and dm_re_EX_DM for the writeback mux.
- Raises stall_DM to freeze the pipeline while a memory access is outstanding.
- Aborts hung accesses with a timeout and a sticky error flag.

Parameters:
TIMEOUT_CYC, 64, cycles in BUSY without mem_ack before the access is aborted (legal range 2..255).
ADDR_W, 16, width of the memory address.

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset; asynchronous assert, active-low
dm_re_ID_EX  in  1  load request
dm_we_ID_EX  in  1  store request
addr_ID_EX  in  ADDR_W  effective address from the ALU
wrt_data_ID_EX  in  16  store data
stall_in  in  1  downstream stall; blocks acceptance of a new request
err_clr  in  1  clears dm_err
mem_req  out  1  memory request, held until acknowledged
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  ADDR_W  registered address
mem_wdata  out  16  registered store data
mem_ack  in  1  memory completion, one-cycle pulse
mem_rdata  in  16  read data, valid when mem_ack=1
dm_rd_data_EX_DM  out  16  load result for writeback
dm_re_EX_DM  out  1  marks dm_rd_data_EX_DM as the writeback source
stall_DM  out  1  pipeline stall request
dm_err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n=0, async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, dm_rd_data_EX_DM=0, dm_re_EX_DM=0, dm_err=0; timeout counter=0.
- FSM states: IDLE, BUSY.
- IDLE -> BUSY:
  - Condition: at posedge with (dm_re_ID_EX | dm_we_ID_EX) & !stall_in.
  - Captures addr and wdata; mem_we=dm_we_ID_EX; mem_req=1 from the next cycle.
  - If re and we are both high, the store wins and the read is discarded.
  - With no request, or with stall_in=1: stay IDLE; dm_re_EX_DM <= 0.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Timeout counter increments each cycle mem_ack=0.
  - Request inputs are ignored, whatever their value.
- BUSY -> IDLE on mem_ack=1:
  - mem_req <= 0.
  - Read: dm_rd_data_EX_DM <= mem_rdata and dm_re_EX_DM <= 1 for exactly one cycle.
  - Write: dm_rd_data_EX_DM keeps its previous value and dm_re_EX_DM <= 0.
  - Counter cleared.
- Timeout:
  - Trigger: counter reaches TIMEOUT_CYC-1 with mem_ack=0.
  - Action: mem_req <= 0, dm_err <= 1, state -> IDLE.
  - Read aborts load dm_rd_data_EX_DM <= 16'h0000 with dm_re_EX_DM <= 1 for one cycle, so writeback stays deterministic.
  - mem_ack arriving on the timeout cycle counts as success; no error.
- mem_ack while IDLE: ignored.
- stall_DM = (state==BUSY) & !mem_ack. It is combinational from state, so it drops in the ack cycle to let the pipeline advance on the same edge the result is captured.
- Minimum access latency: request sampled at edge N, mem_req high from N, earliest ack at edge N+1, 1 stall cycle.
- Back-to-back: a new request may be accepted at the edge after returning to IDLE; there is no dead cycle beyond IDLE.
- dm_err: set by a timeout, cleared by err_clr=1 at posedge. If a timeout and err_clr occur on the same edge, set wins.
- Reset mid-access: mem_req deasserts immediately (async) and any in-flight ack is dropped.

Test Plan:
1. Load, addr=16'h0040, memory acks 3 cycles after mem_req -> stall_DM high 3 cycles; dm_rd_data_EX_DM=mem_rdata (16'hBEEF) with dm_re_EX_DM=1 for one cycle; mem_req low after the ack edge.
2. Store, addr=16'h0010, data=16'h1234, ack in 1 cycle -> mem_we=1, mem_wdata=16'h1234 stable through ack; dm_re_EX_DM stays 0; dm_rd_data unchanged.
3. Simultaneous re=1, we=1 -> mem_we=1 (store wins); no load result produced.
4. TIMEOUT_CYC=8, load, never ack -> mem_req drops after 8 cycles; dm_err=1; dm_rd_data=0 with dm_re_EX_DM=1 for one cycle. err_clr pulse -> dm_err=0.
5. Request with stall_in=1 for 2 cycles, then stall_in=0 -> no mem_req until stall_in falls; then a normal access.
6. rst_n low mid-BUSY, then a late mem_ack after release -> all outputs at reset values immediately; the late ack is ignored; the next load completes normally.
